// File: rtl/cpu_defs.sv
// Shared CPU definitions: register-address width, $0 constant, write-port
// mux select encodings and the write-port arbiter state encoding.
package cpu_defs;
  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic SEL_PIPE = 1'b1;
  localparam logic SEL_SEC  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_t;
endpackage

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, a single
// holding register buffers the secondary writer, starvation forces a WB stall.
module rf_wport_arbiter
  import cpu_defs::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0]     pipe_wdata,
  input  logic                  sec_valid,
  output logic                  sec_ready,
  input  logic [REG_ADDR_W-1:0] sec_waddr,
  input  logic [DATA_W-1:0]     sec_wdata,
  output logic                  rf_we,
  output logic                  rf_sel,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  stall_req
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t            state;
  logic                  hv;
  logic [REG_ADDR_W-1:0] haddr;
  logic [DATA_W-1:0]     hdata;
  logic [3:0]            cnt;
  logic [3:0]            cnt_inc;
  logic                  pipe_win;
  logic                  handshake;

  assign sec_ready = !rst && (state == ST_IDLE) && !hv;
  assign handshake = sec_valid && sec_ready;
  // A write to $0 is not a real pipeline write and leaves the port free.
  assign pipe_win  = pipe_we && (pipe_waddr != REG_ZERO);

  always_comb begin
    cnt_inc = cnt;
    if (cnt != 4'hF) cnt_inc = cnt + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      hv        <= 1'b0;
      haddr     <= '0;
      hdata     <= '0;
      cnt       <= '0;
      rf_we     <= 1'b0;
      rf_sel    <= SEL_SEC;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      stall_req <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      if (pipe_win) begin
        rf_we    <= 1'b1;
        rf_sel   <= SEL_PIPE;
        rf_waddr <= pipe_waddr;
        rf_wdata <= pipe_wdata;
        if (hv) begin
          if (haddr == pipe_waddr) begin
            // Newer pipeline result supersedes the held one.
            hv        <= 1'b0;
            cnt       <= '0;
            state     <= ST_IDLE;
            stall_req <= 1'b0;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc >= LIMIT) begin
              state     <= ST_FORCE;
              stall_req <= 1'b1;
            end
          end
        end
      end else if (hv) begin
        if (haddr != REG_ZERO) begin
          rf_we    <= 1'b1;
          rf_sel   <= SEL_SEC;
          rf_waddr <= haddr;
          rf_wdata <= hdata;
        end
        hv        <= 1'b0;
        cnt       <= '0;
        state     <= ST_IDLE;
        stall_req <= 1'b0;
      end

      if (handshake) begin
        hv    <= 1'b1;
        haddr <= sec_waddr;
        hdata <= sec_wdata;
        cnt   <= '0;
        state <= ST_PEND;
      end
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: directed scenarios followed by
// randomized traffic compared against a rule-level reference model.
module tb_rf_wport_arbiter;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LIMIT  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              pipe_we;
  logic [4:0]        pipe_waddr;
  logic [DATA_W-1:0] pipe_wdata;
  logic              sec_valid;
  logic              sec_ready;
  logic [4:0]        sec_waddr;
  logic [DATA_W-1:0] sec_wdata;
  logic              rf_we;
  logic              rf_sel;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              stall_req;

  int checks = 0;
  int failures = 0;

  // reference model: one pending secondary entry plus expected port outputs
  logic              m_pend;
  logic [4:0]        m_addr;
  logic [DATA_W-1:0] m_data;
  int                m_loss;
  logic              e_we, e_sel, e_stall;
  logic [4:0]        e_addr;
  logic [DATA_W-1:0] e_data;

  rf_wport_arbiter #(.DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .sec_valid(sec_valid), .sec_ready(sec_ready),
    .sec_waddr(sec_waddr), .sec_wdata(sec_wdata),
    .rf_we(rf_we), .rf_sel(rf_sel), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pend = 1'b0; m_addr = '0; m_data = '0; m_loss = 0;
    e_we = 1'b0; e_sel = 1'b0; e_addr = '0; e_data = '0; e_stall = 1'b0;
  endtask

  task automatic idle_inputs();
    pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    sec_valid = 1'b0; sec_waddr = '0; sec_wdata = '0;
  endtask

  // Predict the effect of the current inputs, then advance one clock.
  task automatic tick();
    logic hs;
    logic real_pipe;
    hs = sec_valid && !m_pend;
    real_pipe = pipe_we && (pipe_waddr != 5'd0);
    e_we = 1'b0;
    if (real_pipe) begin
      e_we = 1'b1; e_sel = 1'b1; e_addr = pipe_waddr; e_data = pipe_wdata;
      if (m_pend) begin
        if (m_addr == pipe_waddr) begin
          m_pend = 1'b0; m_loss = 0;
        end else if (m_loss < 15) begin
          m_loss++;
        end
      end
    end else if (m_pend) begin
      if (m_addr != 5'd0) begin
        e_we = 1'b1; e_sel = 1'b0; e_addr = m_addr; e_data = m_data;
      end
      m_pend = 1'b0; m_loss = 0;
    end
    if (hs) begin
      m_pend = 1'b1; m_addr = sec_waddr; m_data = sec_wdata; m_loss = 0;
    end
    e_stall = m_pend && (m_loss >= LIMIT);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); model_reset();
    #2;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b want=0", rf_we); end
    checks++; if (rf_sel !== 1'b0) begin failures++; $display("FAIL reset_sel got=%0b want=0", rf_sel); end
    checks++; if (rf_waddr !== 5'd0) begin failures++; $display("FAIL reset_addr got=%0d want=0", rf_waddr); end
    checks++; if (rf_wdata !== '0) begin failures++; $display("FAIL reset_data got=%h want=0", rf_wdata); end
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b want=0", stall_req); end
    checks++; if (sec_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b want=0", sec_ready); end
    @(posedge clk); #1;
    rst = 1'b0; #1;
    checks++; if (sec_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_release got=%0b want=1", sec_ready); end
  endtask

  task automatic test_pipe_write();
    pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'h1234;
    tick();
    pipe_we = 1'b0;
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL pipe_we got=%0b want=1", rf_we); end
    checks++; if (rf_sel !== 1'b1) begin failures++; $display("FAIL pipe_sel got=%0b want=1", rf_sel); end
    checks++; if (rf_waddr !== 5'd5) begin failures++; $display("FAIL pipe_addr got=%0d want=5", rf_waddr); end
    checks++; if (rf_wdata !== 32'h1234) begin failures++; $display("FAIL pipe_data got=%h want=1234", rf_wdata); end
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL pipe_idle_we got=%0b want=0", rf_we); end
    checks++; if (rf_waddr !== 5'd5) begin failures++; $display("FAIL pipe_hold_addr got=%0d want=5", rf_waddr); end
  endtask

  task automatic test_sec_write();
    sec_valid = 1'b1; sec_waddr = 5'd9; sec_wdata = 32'hBEEF;
    checks++; if (sec_ready !== 1'b1) begin failures++; $display("FAIL sec_ready_n got=%0b want=1", sec_ready); end
    tick();
    sec_valid = 1'b0;
    checks++; if (sec_ready !== 1'b0) begin failures++; $display("FAIL sec_ready_n1 got=%0b want=0", sec_ready); end
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL sec_we_n1 got=%0b want=0", rf_we); end
    tick();
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL sec_we_n2 got=%0b want=1", rf_we); end
    checks++; if (rf_sel !== 1'b0) begin failures++; $display("FAIL sec_sel got=%0b want=0", rf_sel); end
    checks++; if (rf_waddr !== 5'd9) begin failures++; $display("FAIL sec_addr got=%0d want=9", rf_waddr); end
    checks++; if (rf_wdata !== 32'hBEEF) begin failures++; $display("FAIL sec_data got=%h want=beef", rf_wdata); end
    checks++; if (sec_ready !== 1'b1) begin failures++; $display("FAIL sec_ready_n2 got=%0b want=1", sec_ready); end
  endtask

  task automatic test_starvation();
    sec_valid = 1'b1; sec_waddr = 5'd7; sec_wdata = 32'h7777;
    pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h3;
    tick();
    sec_valid = 1'b0;
    for (int i = 0; i < int'(LIMIT); i++) begin
      pipe_wdata = 32'h30 + i;
      tick();
      checks++; if (rf_sel !== 1'b1 || rf_waddr !== 5'd3) begin failures++; $display("FAIL starve_pipe%0d got sel=%0b addr=%0d want sel=1 addr=3", i, rf_sel, rf_waddr); end
      checks++; if (stall_req !== (i == int'(LIMIT) - 1)) begin failures++; $display("FAIL starve_stall%0d got=%0b want=%0b", i, stall_req, (i == int'(LIMIT) - 1)); end
    end
    pipe_we = 1'b0;
    tick();
    checks++; if (rf_we !== 1'b1 || rf_sel !== 1'b0 || rf_waddr !== 5'd7) begin failures++; $display("FAIL starve_force got we=%0b sel=%0b addr=%0d want we=1 sel=0 addr=7", rf_we, rf_sel, rf_waddr); end
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL starve_release got=%0b want=0", stall_req); end
    checks++; if (sec_ready !== 1'b1) begin failures++; $display("FAIL starve_ready got=%0b want=1", sec_ready); end
  endtask

  task automatic test_supersede();
    sec_valid = 1'b1; sec_waddr = 5'd12; sec_wdata = 32'h55;
    tick();
    sec_valid = 1'b0;
    pipe_we = 1'b1; pipe_waddr = 5'd12; pipe_wdata = 32'hAA;
    tick();
    pipe_we = 1'b0;
    checks++; if (rf_we !== 1'b1 || rf_sel !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'hAA) begin failures++; $display("FAIL supersede_write got we=%0b sel=%0b addr=%0d data=%h want 1 1 12 aa", rf_we, rf_sel, rf_waddr, rf_wdata); end
    checks++; if (sec_ready !== 1'b1) begin failures++; $display("FAIL supersede_ready got=%0b want=1", sec_ready); end
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL supersede_drop got=%0b want=0", rf_we); end
  endtask

  task automatic test_reg_zero();
    sec_valid = 1'b1; sec_waddr = 5'd4; sec_wdata = 32'h44;
    tick();
    sec_valid = 1'b0;
    pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'h99;
    tick();
    pipe_we = 1'b0;
    checks++; if (rf_we !== 1'b1 || rf_sel !== 1'b0 || rf_waddr !== 5'd4 || rf_wdata !== 32'h44) begin failures++; $display("FAIL zero_pipe got we=%0b sel=%0b addr=%0d data=%h want 1 0 4 44", rf_we, rf_sel, rf_waddr, rf_wdata); end
    sec_valid = 1'b1; sec_waddr = 5'd0; sec_wdata = 32'hDEAD;
    checks++; if (sec_ready !== 1'b1) begin failures++; $display("FAIL zero_sec_accept got=%0b want=1", sec_ready); end
    tick();
    sec_valid = 1'b0;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL zero_sec_n1 got=%0b want=0", rf_we); end
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL zero_sec_n2 got=%0b want=0", rf_we); end
    checks++; if (sec_ready !== 1'b1) begin failures++; $display("FAIL zero_sec_ready got=%0b want=1", sec_ready); end
  endtask

  task automatic test_reset_mid();
    sec_valid = 1'b1; sec_waddr = 5'd20; sec_wdata = 32'h2020;
    tick();
    sec_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b0 || rf_sel !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== '0 || stall_req !== 1'b0) begin failures++; $display("FAIL midreset_out got we=%0b sel=%0b addr=%0d data=%h stall=%0b want all 0", rf_we, rf_sel, rf_waddr, rf_wdata, stall_req); end
    checks++; if (sec_ready !== 1'b0) begin failures++; $display("FAIL midreset_ready got=%0b want=0", sec_ready); end
    @(posedge clk); #1;
    rst = 1'b0; model_reset(); #1;
    checks++; if (sec_ready !== 1'b1) begin failures++; $display("FAIL midreset_release got=%0b want=1", sec_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL midreset_nowrite%0d got=%0b want=0", i, rf_we); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      pipe_we    = e_stall ? 1'b0 : ($urandom_range(0, 99) < 75);
      pipe_waddr = 5'($urandom_range(0, 7));
      pipe_wdata = $urandom;
      sec_valid  = 1'($urandom_range(0, 1));
      sec_waddr  = 5'($urandom_range(0, 7));
      sec_wdata  = $urandom;
      tick();
      checks++;
      if (rf_we !== e_we || rf_sel !== e_sel || rf_waddr !== e_addr || rf_wdata !== e_data) begin
        failures++;
        $display("FAIL rand_port cyc=%0d got we=%0b sel=%0b addr=%0d data=%h want we=%0b sel=%0b addr=%0d data=%h",
                 i, rf_we, rf_sel, rf_waddr, rf_wdata, e_we, e_sel, e_addr, e_data);
      end
      checks++;
      if (stall_req !== e_stall || sec_ready !== !m_pend) begin
        failures++;
        $display("FAIL rand_ctrl cyc=%0d got stall=%0b ready=%0b want stall=%0b ready=%0b",
                 i, stall_req, sec_ready, e_stall, !m_pend);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_sec_write();
    test_starvation();
    test_supersede();
    test_reg_zero();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Schedules the single register-file write port between two writers:
  - the in-order pipeline writeback, which has priority and no backpressure;
  - a long-latency secondary writer (divider/load-return) with a valid/ready handshake.
- Drives the select, 5-bit address, data and enable that feed the write-port address/data muxes. Select convention: 1 = pipeline (a), 0 = secondary (b).
- Sits between the WB stage and the register file.
- Guarantees forward progress for the secondary writer with a starvation counter that requests a one-cycle pipeline stall.

Parameters:
- DATA_W, 32, width of write data.
- STARVE_LIMIT, 4, consecutive lost arbitrations by a pending secondary entry before a forced stall. Legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- pipe_we  in  1  pipeline writeback enable
- pipe_waddr  in  5  pipeline destination register
- pipe_wdata  in  DATA_W  pipeline write data
- sec_valid  in  1  secondary writer has a result
- sec_ready  out  1  arbiter can accept a secondary result
- sec_waddr  in  5  secondary destination register
- sec_wdata  in  DATA_W  secondary write data
- rf_we  out  1  register-file write enable (registered)
- rf_sel  out  1  write-port mux select: 1 = pipeline, 0 = secondary (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  DATA_W  register-file write data (registered)
- stall_req  out  1  pipeline must freeze WB; pipe_we must be 0 while high (registered)

Behaviour:
- Reset (async, rst=1):
  - rf_we=0, rf_sel=0, rf_waddr=0, rf_wdata=0, stall_req=0, sec_ready=0.
  - Holding register empty, starvation counter=0, state=IDLE.
  - Reset mid-operation discards any held entry without writing it.
- Storage: one holding register (hv, haddr, hdata).
- sec_ready = !rst && state==IDLE && !hv. A handshake (sec_valid && sec_ready) at cycle N loads the holding register; hv=1 from N+1.
- Pipeline latency: pipe_we at cycle N gives rf_we/rf_sel=1/rf_waddr/rf_wdata visible at N+1.
- Secondary latency: earliest write visible at N+2 after the handshake.
- Per-cycle decision, registered at the clock edge:
  1. pipe_we && pipe_waddr!=0: write the pipeline entry (rf_sel=1).
  2. Else if hv: write the holding entry (rf_sel=0); hv cleared.
  3. Else: rf_we=0. rf_sel, rf_waddr and rf_wdata hold their previous values.
- Register $0:
  - A pipeline write to address 0 is suppressed and counts as no pipeline write, so the secondary may use that cycle.
  - A secondary entry with address 0 is accepted, then dropped with no write.
- Supersede: if hv and the pipeline writes haddr in the same cycle, the pipeline write proceeds and the holding entry is dropped (the newer result wins). The counter resets.
- Starvation counter:
  - Increments each cycle hv=1 and the pipeline wins.
  - Clears when hv clears.
  - On reaching STARVE_LIMIT, the next state is FORCE.
- FSM:
  - IDLE -> PEND on handshake.
  - PEND -> IDLE when the holding entry is written or dropped.
  - PEND -> FORCE when count==STARVE_LIMIT.
  - FORCE: stall_req=1 for the cycle(s) in FORCE. The holding entry writes in the first FORCE cycle with pipe_we=0, then -> IDLE and stall_req=0 at the next edge.
  - If pipe_we=1 in FORCE (protocol violation), the pipeline still wins and the block stays in FORCE.
- Simultaneous handshake and pipeline write in IDLE: both are accepted. The pipeline writes at N+1 and the held entry competes from N+1.

Decomposition:
- Shared package (cpu_defs):
  - REG_ADDR_W=5;
  - REG_ZERO=5'd0;
  - SEL_PIPE=1'b1, SEL_SEC=1'b0;
  - arbiter state encoding IDLE/PEND/FORCE.
- No sub-module is needed. The existing 5-bit and DATA_W 2:1 muxes are instantiated outside this block and driven by rf_sel.

Test Plan:
1. Reset: assert rst mid-PEND with hv=1 -> all outputs 0 and sec_ready=0 immediately; after release, sec_ready=1 and no write of the held entry ever occurs.
2. Lone pipeline write: pipe_we=1, waddr=5, wdata=0x1234 at cycle N -> at N+1 rf_we=1, rf_sel=1, rf_waddr=5, rf_wdata=0x1234.
3. Lone secondary write: sec_valid with waddr=9, wdata=0xBEEF at N, pipe idle -> sec_ready=0 at N+1; at N+2 rf_we=1, rf_sel=0, rf_waddr=9; sec_ready=1 again at N+2.
4. Starvation: hold secondary (waddr=7) while the pipeline writes r3 every cycle -> after 4 pipeline wins stall_req=1; with pipe_we=0 the next write is rf_sel=0, rf_waddr=7; stall_req drops the cycle after.
5. Supersede: hv with haddr=12, then pipeline writes r12=0xAA -> only the 0xAA write occurs, hv clears, sec_ready returns to 1.
6. $0 handling: pipeline writes r0 while hv (haddr=4) -> the secondary write to r4 takes that cycle. Secondary waddr=0 -> accepted with no rf_we pulse.
